// File: rtl/scrambler_pkg.sv
// scrambler_pkg: widths, tap positions and single-step function for the 301-bit
// multiplicative scrambler shared by the stream controller and its step unit.
package scrambler_pkg;
    localparam int STATE_W = 301;
    localparam int WORD_W  = 16;
    localparam int TAP_A   = 181;
    localparam int TAP_B   = 209;
    localparam int TAP_C   = 215;
    typedef logic [STATE_W-1:0] state_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef enum logic {UNSEEDED, RUN} ctrl_state_e;
    // One shift of the state; bit 0 receives the scrambled data bit.
    function automatic state_t scr_step(input state_t s, input logic d);
        state_t n;
        logic   msb;
        msb      = s[STATE_W-1];
        n        = {s[STATE_W-2:0], msb ^ d};
        n[TAP_A] = msb ^ s[TAP_A-1];
        n[TAP_B] = msb ^ s[TAP_B-1];
        n[TAP_C] = msb ^ s[TAP_C-1];
        return n;
    endfunction
endpackage

// File: rtl/scrambler_stream_ctrl_if.sv
// scrambler_stream_ctrl_if: seed, input/output stream handshake and status of the
// scrambler stream controller; slave is the controller, master is its environment.
interface scrambler_stream_ctrl_if #(parameter int CNT_W = 6);
    import scrambler_pkg::*;
    logic             seed_load;
    state_t           seed_value;
    logic             in_valid;
    logic             in_ready;
    word_t            in_data;
    logic             out_valid;
    logic             out_ready;
    word_t            out_data;
    logic             out_sof;
    logic             out_eof;
    logic             seeded;
    logic [CNT_W-1:0] frame_cnt;
    modport master (
        output seed_load, seed_value, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sof, out_eof, seeded, frame_cnt
    );
    modport slave (
        input  seed_load, seed_value, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sof, out_eof, seeded, frame_cnt
    );
endinterface

// File: rtl/scrambler_step16.sv
// scrambler_step16: combinational 16-step scrambler advance; data_o[i] is the
// scrambled bit of step i, which ends up at state bit WORD_W-1-i.
module scrambler_step16
    import scrambler_pkg::*;
(
    input  state_t state_i,
    input  word_t  data_i,
    output state_t state_o,
    output word_t  data_o
);
    always_comb begin
        state_o = state_i;
        for (int i = 0; i < WORD_W; i++) state_o = scr_step(state_o, data_i[i]);
    end
    for (genvar g = 0; g < WORD_W; g++) begin : g_rev
        assign data_o[g] = state_o[WORD_W-1-g];
    end
endmodule

// File: rtl/scrambler_stream_ctrl.sv
// scrambler_stream_ctrl: valid/ready wrapper owning scrambler state, seed and
// frame counter; one-cycle latency, optional reseed at every frame start.
module scrambler_stream_ctrl
    import scrambler_pkg::*;
#(
    parameter int FRAME_WORDS      = 64,
    parameter bit RESEED_PER_FRAME = 1'b1,
    localparam int CNT_W           = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1
) (
    input logic                     clk,
    input logic                     rst,
    scrambler_stream_ctrl_if.slave  bus
);
    ctrl_state_e      state_q, state_d;
    state_t           scr_q, scr_d, seed_q, seed_d, scr_nxt;
    word_t            od_q, od_d, scr_word;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ov_q, ov_d, sof_q, sof_d, eof_q, eof_d;
    logic             in_ready, accept, last;

    scrambler_step16 u_step (
        .state_i (scr_q),
        .data_i  (bus.in_data),
        .state_o (scr_nxt),
        .data_o  (scr_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= UNSEEDED;
        else     state_q <= state_d;
    end

    always_comb state_d = bus.seed_load ? RUN : state_q;

    always_comb in_ready = (state_q == RUN) && !bus.seed_load && (!ov_q || bus.out_ready);

    assign accept = bus.in_valid && in_ready;
    assign last   = cnt_q == CNT_W'(FRAME_WORDS - 1);

    // An explicit seed load outranks the end-of-frame reseed; the emitted word always uses scr_nxt.
    always_comb begin
        scr_d  = bus.seed_load ? bus.seed_value :
                 accept ? ((RESEED_PER_FRAME && last) ? seed_q : scr_nxt) : scr_q;
        seed_d = bus.seed_load ? bus.seed_value : seed_q;
        cnt_d  = bus.seed_load ? '0 : accept ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        ov_d   = accept || (ov_q && !bus.out_ready);
        od_d   = accept ? scr_word : od_q;
        sof_d  = accept ? (cnt_q == '0) : sof_q;
        eof_d  = accept ? last : eof_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scr_q  <= '0;
            seed_q <= '0;
            cnt_q  <= '0;
            ov_q   <= 1'b0;
            od_q   <= '0;
            sof_q  <= 1'b0;
            eof_q  <= 1'b0;
        end else begin
            scr_q  <= scr_d;
            seed_q <= seed_d;
            cnt_q  <= cnt_d;
            ov_q   <= ov_d;
            od_q   <= od_d;
            sof_q  <= sof_d;
            eof_q  <= eof_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_sof   = sof_q;
    assign bus.out_eof   = eof_q;
    assign bus.seeded    = state_q == RUN;
    assign bus.frame_cnt = cnt_q;
endmodule
